// File: rtl/ahbl_sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_sram_arb_pkg
// Shared definitions for the two-port SRAM arbiter / power-up sequencer.
//   arb_state_t : sequencer state (INIT = zero-fill running, RUN = arbitration)
//   NUM_LANES   : byte lanes per memory word
//   LANE_W      : bits per byte lane (the SRAM uses 10-bit lanes)
// ---------------------------------------------------------------------------
package ahbl_sram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 10;

endpackage

// File: rtl/ahbl_sram_arb_rr2.sv
// ---------------------------------------------------------------------------
// ahbl_sram_arb_rr2
// Two-way round-robin grant with burst lock.
// Ports:
//   HCLK, HRESETN : clock, synchronous active-low reset
//   valid[1:0]    : request from each port
//   lock[1:0]     : requester wants to keep priority after its access
//   accept        : arbitration enabled; every grant issued is taken
//   gnt[1:0]      : one-hot (or zero) combinational grant
//   rr            : port that wins when both request
// ---------------------------------------------------------------------------
module ahbl_sram_arb_rr2 (
    input  logic       HCLK,
    input  logic       HRESETN,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       rr
);

    logic r_rr;

    // A lone requester always wins; a tie goes to the port named by r_rr.
    always_comb begin
        gnt = 2'b00;
        if (accept) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_rr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After an access the pointer moves to the other port, unless the
    // accessing port asked to lock, in which case it keeps priority.
    // An idle locked owner loses the cycle but gets the pointer back
    // because the other port's access (unlocked) points rr at it.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_rr <= 1'b0;
        end else if (gnt[0]) begin
            r_rr <= ~lock[0];
        end else if (gnt[1]) begin
            r_rr <= lock[1];
        end
    end

    assign rr = r_rr;

endmodule

// File: rtl/ahbl_sram_arb.sv
// ---------------------------------------------------------------------------
// ahbl_sram_arb
// Shares the single port of the 40-bit SRAM between the AHB slave bridge
// (port 0) and the DMA/debug path (port 1), and optionally zero-fills the
// array after reset.
// Build option: define AHBL_SRAM_ARB_INIT_EN to compile in the zero-fill
// sequencer; without it the block comes out of reset ready to arbitrate.
// Ports:
//   HCLK, HRESETN             : clock, synchronous active-low reset
//   reqN_valid/write/lock     : request, direction, keep-grant for bursts
//   reqN_addr/byteen/wdata    : word address, lane enables, write data
//   reqN_ready                : grant (access happens on valid & ready)
//   reqN_rvalid/rdata         : read return, one cycle after acceptance
//   init_done                 : array usable
//   mem_wen/ren/addr/byteen/wdata/rdata : SRAM port (rdata registered)
// ---------------------------------------------------------------------------
module ahbl_sram_arb
    import ahbl_sram_arb_pkg::*;
#(
    parameter  int MEM_DEPTH = 65536,
    parameter  int DW        = NUM_LANES * LANE_W,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic                 req0_lock,
    input  logic [AW-1:0]        req0_addr,
    input  logic [NUM_LANES-1:0] req0_byteen,
    input  logic [DW-1:0]        req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_rvalid,
    output logic [DW-1:0]        req0_rdata,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic                 req1_lock,
    input  logic [AW-1:0]        req1_addr,
    input  logic [NUM_LANES-1:0] req1_byteen,
    input  logic [DW-1:0]        req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_rvalid,
    output logic [DW-1:0]        req1_rdata,
    output logic                 init_done,
    output logic                 mem_wen,
    output logic                 mem_ren,
    output logic [AW-1:0]        mem_addr,
    output logic [NUM_LANES-1:0] mem_byteen,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    logic          w_run;
    logic          w_fill;
    logic [AW-1:0] w_fillAddr;
    logic [1:0]    w_gnt;
    logic          w_unusedRr;
    logic          r_rdPend;
    logic          r_rdOwner;

`ifdef AHBL_SRAM_ARB_INIT_EN
    arb_state_t    r_state;
    arb_state_t    w_stateNext;
    logic [AW-1:0] r_fillCnt;
    logic [AW-1:0] w_fillCntNext;

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_state   <= INIT;
            r_fillCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_fillCnt <= w_fillCntNext;
        end
    end

    // Terminal count compares against MEM_DEPTH-1 rather than relying on
    // wrap-around, so non-power-of-two depths stop at the right word.
    always_comb begin
        w_stateNext   = r_state;
        w_fillCntNext = r_fillCnt;
        if (r_state == INIT) begin
            w_fillCntNext = r_fillCnt + AW'(1);
            if (r_fillCnt == AW'(MEM_DEPTH - 1)) begin
                w_stateNext   = RUN;
                w_fillCntNext = '0;
            end
        end
    end

    assign w_run      = (r_state == RUN);
    assign w_fill     = (r_state == INIT);
    assign w_fillAddr = r_fillCnt;
`else
    assign w_run      = 1'b1;
    assign w_fill     = 1'b0;
    assign w_fillAddr = '0;
`endif

    assign init_done = w_run;

    ahbl_sram_arb_rr2 u_rr2 (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .valid   ({req1_valid, req0_valid}),
        .lock    ({req1_lock, req0_lock}),
        .accept  (w_run & HRESETN),
        .gnt     (w_gnt),
        .rr      (w_unusedRr)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    // The memory port carries either the fill write or the granted
    // access; idle fields are forced to 0 so the pins do not toggle.
    always_comb begin
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        mem_addr   = '0;
        mem_byteen = '0;
        mem_wdata  = '0;
        if (w_fill && HRESETN) begin
            mem_wen    = 1'b1;
            mem_addr   = w_fillAddr;
            mem_byteen = '1;
        end else if (w_gnt[0]) begin
            mem_addr = req0_addr;
            if (req0_write) begin
                mem_wen    = 1'b1;
                mem_byteen = req0_byteen;
                mem_wdata  = req0_wdata;
            end else begin
                mem_ren = 1'b1;
            end
        end else if (w_gnt[1]) begin
            mem_addr = req1_addr;
            if (req1_write) begin
                mem_wen    = 1'b1;
                mem_byteen = req1_byteen;
                mem_wdata  = req1_wdata;
            end else begin
                mem_ren = 1'b1;
            end
        end
    end

    // Remember who issued the read so the registered SRAM output can be
    // flagged to the right requester on the next cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            r_rdPend  <= 1'b0;
            r_rdOwner <= 1'b0;
        end else begin
            r_rdPend  <= mem_ren;
            r_rdOwner <= w_gnt[1];
        end
    end

    // Gating with HRESETN drops a read return that is in flight when
    // reset arrives.
    assign req0_rvalid = r_rdPend & ~r_rdOwner & HRESETN;
    assign req1_rvalid = r_rdPend &  r_rdOwner & HRESETN;
    assign req0_rdata  = mem_rdata;
    assign req1_rdata  = mem_rdata;

endmodule

// File: tb/tb_ahbl_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_ahbl_sram_arb
// Bench for ahbl_sram_arb with MEM_DEPTH=16, including a behavioural SRAM
// with registered read data. Honours AHBL_SRAM_ARB_INIT_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahbl_sram_arb;

    localparam int MEM_DEPTH = 16;
    localparam int DW        = 40;
    localparam int AW        = 4;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          req0_valid, req0_write, req0_lock;
    logic [AW-1:0] req0_addr;
    logic [3:0]    req0_byteen;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready, req0_rvalid;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid, req1_write, req1_lock;
    logic [AW-1:0] req1_addr;
    logic [3:0]    req1_byteen;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready, req1_rvalid;
    logic [DW-1:0] req1_rdata;
    logic          init_done;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_byteen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] memRdata = '0;

    typedef struct {
        logic [1:0]    valid, write, lock;
        logic [AW-1:0] addr0, addr1;
        logic [3:0]    be0, be1;
        logic [DW-1:0] wd0, wd1;
        logic [1:0]    expGnt;
    } stim_t;

    typedef struct {
        int            due;
        logic          port;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sbQ[$];
    logic [DW-1:0] refMem [MEM_DEPTH];
    logic [DW-1:0] sram [MEM_DEPTH] = '{default: '1};
    stim_t         vecs [12];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;

    ahbl_sram_arb #(.MEM_DEPTH(MEM_DEPTH), .DW(DW)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_byteen(req0_byteen), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_byteen(req1_byteen), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .init_done(init_done),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(memRdata)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Behavioural SRAM: lane-masked write, registered read.
    always @(posedge HCLK) begin
        if (mem_wen) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_byteen[l]) sram[mem_addr][l*10 +: 10] <= mem_wdata[l*10 +: 10];
            end
        end
        if (mem_ren) memRdata <= sram[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read returns: pop the scoreboard when an entry is due, otherwise
    // both rvalid lines must be quiet.
    always @(negedge HCLK) begin
        sb_t e;
        if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
            e = sbQ.pop_front();
            checkOutput("rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(e.port ? 2'b10 : 2'b01));
            checkOutput("rdata0", 64'(req0_rdata), 64'(e.data));
            checkOutput("rdata1", 64'(req1_rdata), 64'(e.data));
        end else begin
            checkOutput("rvalidIdle", 64'({req1_rvalid, req0_rvalid}), 64'(2'b00));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idleInputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_lock = 1'b0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_lock = 1'b0;
    endtask

    function automatic stim_t mk(input int i, input logic [1:0] v, input logic [1:0] w,
                                 input logic [1:0] l, input logic [AW-1:0] a0,
                                 input logic [AW-1:0] a1, input logic [1:0] g);
        stim_t s;
        s.valid = v; s.write = w; s.lock = l;
        s.addr0 = a0; s.addr1 = a1;
        s.be0 = 4'hF; s.be1 = 4'hF;
        s.wd0 = {8'hA0, 32'(i)};
        s.wd1 = {8'hB1, 32'(i)};
        s.expGnt = g;
        return s;
    endfunction

    // Drive one cycle of requests in the current cycle and check the
    // combinational grant and memory port; reads go to the scoreboard.
    task automatic driveCheck(input stim_t s, input string name, input bit noPush);
        logic          expW, expR, p;
        logic [AW-1:0] expA;
        logic [3:0]    be;
        logic [DW-1:0] wd;
        sb_t           e;
        req0_valid = s.valid[0]; req0_write = s.write[0]; req0_lock = s.lock[0];
        req0_addr = s.addr0; req0_byteen = s.be0; req0_wdata = s.wd0;
        req1_valid = s.valid[1]; req1_write = s.write[1]; req1_lock = s.lock[1];
        req1_addr = s.addr1; req1_byteen = s.be1; req1_wdata = s.wd1;
        #3;
        expW = |(s.expGnt & s.write);
        expR = |(s.expGnt & ~s.write);
        expA = s.expGnt[0] ? s.addr0 : (s.expGnt[1] ? s.addr1 : '0);
        p    = s.expGnt[1];
        checkOutput({name, ".ready"}, 64'({req1_ready, req0_ready}), 64'(s.expGnt));
        checkOutput({name, ".mem"}, 64'({mem_wen, mem_ren, mem_addr}), 64'({expW, expR, expA}));
        if (expW) begin
            be = p ? s.be1 : s.be0;
            wd = p ? s.wd1 : s.wd0;
            checkOutput({name, ".wr"}, 64'({mem_byteen, mem_wdata}), 64'({be, wd}));
            for (int l = 0; l < 4; l++) begin
                if (be[l]) refMem[expA][l*10 +: 10] = wd[l*10 +: 10];
            end
        end
        if (expR && !noPush) begin
            e.due = cyc + 1; e.port = p; e.data = refMem[expA];
            sbQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input stim_t s, input string name, input bit noPush);
        step();
        driveCheck(s, name, noPush);
    endtask

    // Called in the first cycle after reset release; a read request is
    // held high throughout to show requests are ignored during the fill.
    task automatic checkFill(input string name);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = '0;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (k > 0) step();
            #3;
            checkOutput($sformatf("%s[%0d]", name, k),
                        64'({mem_wen, mem_addr, mem_byteen, mem_wdata, init_done, req0_ready, mem_ren}),
                        64'({1'b1, AW'(k), 4'hF, 40'h0, 1'b0, 1'b0, 1'b0}));
        end
        step();
        req0_valid = 1'b0;
        #3;
        checkOutput({name, ".initDone"}, 64'(init_done), 64'(1));
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < MEM_DEPTH; i++) begin
`ifdef AHBL_SRAM_ARB_INIT_EN
            refMem[i] = '0;
`else
            refMem[i] = '1;
`endif
        end
        idleInputs();
        req0_addr = '0; req0_byteen = '0; req0_wdata = '0;
        req1_addr = '0; req1_byteen = '0; req1_wdata = '0;

        // Reset: grants suppressed even with both requests high
        step();
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #3;
        checkOutput("reset.ready", 64'({req1_ready, req0_ready}), 64'(0));
        checkOutput("reset.rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(0));
`ifdef AHBL_SRAM_ARB_INIT_EN
        checkOutput("reset.initDone", 64'(init_done), 64'(0));
`else
        checkOutput("reset.initDone", 64'(init_done), 64'(1));
`endif
        step();
        idleInputs();
        HRESETN = 1'b1;
`ifdef AHBL_SRAM_ARB_INIT_EN
        checkFill("fill");
`else
        #3;
        checkOutput("initDoneNoFill", 64'(init_done), 64'(1));
`endif

        // Arbitration table; rr starts at 0
        vecs[0]  = mk(0,  2'b11, 2'b01, 2'b00, 4'd1, 4'd2, 2'b01);
        vecs[1]  = mk(1,  2'b11, 2'b10, 2'b00, 4'd1, 4'd2, 2'b10);
        vecs[2]  = mk(2,  2'b11, 2'b00, 2'b00, 4'd2, 4'd1, 2'b01);
        vecs[3]  = mk(3,  2'b11, 2'b00, 2'b00, 4'd2, 4'd1, 2'b10);
        vecs[4]  = mk(4,  2'b01, 2'b01, 2'b00, 4'd3, 4'd0, 2'b01);
        vecs[5]  = mk(5,  2'b10, 2'b00, 2'b00, 4'd0, 4'd3, 2'b10);
        vecs[6]  = mk(6,  2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00);
        vecs[7]  = mk(7,  2'b10, 2'b10, 2'b10, 4'd0, 4'd4, 2'b10);
        vecs[8]  = mk(8,  2'b11, 2'b00, 2'b10, 4'd4, 4'd4, 2'b10);
        vecs[9]  = mk(9,  2'b01, 2'b00, 2'b10, 4'd4, 4'd0, 2'b01);
        vecs[10] = mk(10, 2'b11, 2'b00, 2'b00, 4'd3, 4'd1, 2'b10);
        vecs[11] = mk(11, 2'b11, 2'b00, 2'b00, 4'd1, 4'd3, 2'b01);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Port 1 partial-lane write, port 0 read-back
        s = mk(0, 2'b10, 2'b10, 2'b00, 4'd0, 4'd5, 2'b10);
        s.be1 = 4'b0011;
        s.wd1 = 40'h12_3456_789A;
        applyStimulus(s, "wr5", 1'b0);
        s = mk(0, 2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 2'b01);
        applyStimulus(s, "rd5", 1'b0);
        step();
        idleInputs();
        #3;
        checkOutput("rd5.rvalid0", 64'(req0_rvalid), 64'(1));
        checkOutput("rd5.rvalid1", 64'(req1_rvalid), 64'(0));
        checkOutput("rd5.lanes", 64'(req0_rdata[19:0]), 64'(20'h6789A));

        // Point rr at port 0, then a locked 4-beat burst against port 1
        applyStimulus(mk(0, 2'b10, 2'b00, 2'b00, 4'd0, 4'd0, 2'b10), "preBurst", 1'b0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(mk(20 + b, 2'b11, 2'b01, (b < 3) ? 2'b01 : 2'b00,
                             AW'(8 + b), 4'd8, 2'b01), $sformatf("burst%0d", b), 1'b0);
        end
        applyStimulus(mk(24, 2'b11, 2'b01, 2'b00, 4'd12, 4'd8, 2'b10), "afterBurst", 1'b0);

        // Reset while a read is outstanding
        applyStimulus(mk(0, 2'b01, 2'b00, 2'b00, 4'd3, 4'd0, 2'b01), "rdRst", 1'b1);
        step();
        HRESETN = 1'b0;
        idleInputs();
        #3;
        checkOutput("rdRst.rvalid", 64'({req1_rvalid, req0_rvalid}), 64'(0));
        step();
        step();
        HRESETN = 1'b1;
`ifdef AHBL_SRAM_ARB_INIT_EN
        // Interrupt the fill after 5 words; it must restart from 0
        repeat (5) step();
        HRESETN = 1'b0;
        step();
        HRESETN = 1'b1;
        checkFill("refill");
        for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = '0;
        applyStimulus(mk(0, 2'b01, 2'b00, 2'b00, 4'd8, 4'd0, 2'b01), "rdZero", 1'b0);
`else
        driveCheck(mk(0, 2'b01, 2'b00, 2'b00, 4'd5, 4'd0, 2'b01), "rdAfterRst", 1'b0);
`endif

        step();
        idleInputs();
        repeat (3) step();
        checkOutput("sbEmpty", 64'(sbQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
